// File: rtl/tick_divider_bank.sv
// Bank of independent WIDTH-bit down-counting tick dividers with load, one-shot and auto-reload modes.
// Define TICK_DIVIDER_CASCADE_EN to gate each channel's enable with the previous channel's wrap (prescaler chain).

module tick_divider_chan #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 2
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             en,
    input  logic             load,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);
    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count  <= RV;
            reload <= RV;
            done   <= 1'b0;
        end else if (load) begin
            count  <= load_value;
            reload <= load_value;
            done   <= 1'b0;
        end else if (en) begin
            if (count != '0)
                count <= count - 1'b1;
            else if (oneshot)
                done <= 1'b1;   // count parks at zero until the next load
            else
                count <= reload;
        end
    end

    assign tc = (count == '0);
endmodule

module tick_divider_bank #(
    parameter int WIDTH       = 4,
    parameter int CHANNELS    = 4,
    parameter int RESET_VALUE = 2
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS-1:0]       oneshot,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       done
);
    logic [CHANNELS-1:0] en_eff;

`ifdef TICK_DIVIDER_CASCADE_EN
    // chain carries the previous channel's effective enable so wraps ripple down the bank
    always_comb begin
        logic chain;
        en_eff    = '0;
        chain     = enable[0];
        en_eff[0] = enable[0];
        for (int i = 1; i < CHANNELS; i++) begin
            chain     = enable[i] & chain & ~load[i-1] & tc[i-1] & ~oneshot[i-1];
            en_eff[i] = chain;
        end
    end
`else
    assign en_eff = enable;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        tick_divider_chan #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_chan (
            .clk        (clk),
            .resetN     (resetN),
            .en         (en_eff[i]),
            .load       (load[i]),
            .oneshot    (oneshot[i]),
            .load_value (load_value[i*WIDTH +: WIDTH]),
            .count      (count[i*WIDTH +: WIDTH]),
            .tc         (tc[i]),
            .done       (done[i])
        );
    end
endmodule

// File: tb/tb_tick_divider_bank.sv
// Self-checking bench for tick_divider_bank: directed scenarios plus randomized traffic against a per-channel model.
module tb_tick_divider_bank;
    localparam int W  = 4;
    localparam int CH = 4;
    localparam int RV = 2;
`ifdef TICK_DIVIDER_CASCADE_EN
    localparam bit CASCADE = 1'b1;
`else
    localparam bit CASCADE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic [CH-1:0]   enable = '0, load = '0, oneshot = '0;
    logic [CH*W-1:0] load_value = '0;
    logic [CH*W-1:0] count;
    logic [CH-1:0]   tc, done;

    int errors = 0;
    int checks = 0;

    int m_cnt[CH];
    int m_rld[CH];
    bit m_dn[CH];

    tick_divider_bank #(.WIDTH(W), .CHANNELS(CH), .RESET_VALUE(RV)) dut (
        .clk(clk), .resetN(resetN), .enable(enable), .load(load),
        .load_value(load_value), .oneshot(oneshot),
        .count(count), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = RV; m_rld[i] = RV; m_dn[i] = 1'b0;
        end
    endfunction

    // Effective enables are decided from the pre-edge state, then every channel advances.
    function automatic void model_step();
        bit eff[CH];
        for (int i = 0; i < CH; i++) begin
            if (i == 0 || !CASCADE) eff[i] = enable[i];
            else eff[i] = enable[i] && eff[i-1] && !load[i-1] && m_cnt[i-1] == 0 && !oneshot[i-1];
        end
        for (int i = 0; i < CH; i++) begin
            if (load[i]) begin
                m_cnt[i] = int'(load_value[i*W +: W]);
                m_rld[i] = m_cnt[i];
                m_dn[i]  = 1'b0;
            end else if (eff[i]) begin
                if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                else if (oneshot[i]) m_dn[i] = 1'b1;
                else m_cnt[i] = m_rld[i];
            end
        end
    endfunction

    function automatic logic [CH*W-1:0] exp_count();
        logic [CH*W-1:0] r;
        for (int i = 0; i < CH; i++) r[i*W +: W] = W'(m_cnt[i]);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_tc();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = (m_cnt[i] == 0);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_done();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = m_dn[i];
        return r;
    endfunction

    // One clock: inputs are stable across the posedge, outputs are sampled at the following negedge.
    task automatic tick();
        @(posedge clk);
        if (resetN) model_step();
        @(negedge clk);
    endtask

    task automatic set_lv(input int ch, input int v);
        load_value[ch*W +: W] = W'(v);
    endtask

    task automatic test_reset();
        resetN = 1'b0; model_reset();
        repeat (3) tick();
        checks++; if (count !== 16'h2222) begin errors++; $display("FAIL reset_count got=%h exp=%h", count, 16'h2222); end
        checks++; if (tc !== 4'b0000) begin errors++; $display("FAIL reset_tc got=%b exp=%b", tc, 4'b0000); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=%b", done, 4'b0000); end
        resetN = 1'b1;
        tick();
        checks++; if (count !== 16'h2222) begin errors++; $display("FAIL post_reset_hold got=%h exp=%h", count, 16'h2222); end
    endtask

    task automatic test_basic();
        enable = 4'b0001;
        tick(); tick();
        checks++; if (count[3:0] !== 4'd0) begin errors++; $display("FAIL basic_cnt0_zero got=%0d exp=0", count[3:0]); end
        checks++; if (tc[0] !== 1'b1) begin errors++; $display("FAIL basic_tc0 got=%b exp=1", tc[0]); end
        tick();
        checks++; if (count[3:0] !== 4'd2) begin errors++; $display("FAIL basic_reload got=%0d exp=2", count[3:0]); end
        enable = '0;
    endtask

    task automatic test_autoreload();
        int q[$];
        load = 4'b0010; set_lv(1, 5);
        tick();
        load = '0; enable = 4'b0010;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (tc[1]) q.push_back(c);
        end
        enable = '0;
        checks++; if (q.size() != 3) begin errors++; $display("FAIL autoreload_pulses got=%0d exp=3", q.size()); end
        else begin
            checks++; if (q[1] - q[0] != 6 || q[2] - q[1] != 6)
                begin errors++; $display("FAIL autoreload_period got=%0d,%0d exp=6,6", q[1] - q[0], q[2] - q[1]); end
        end
    endtask

    task automatic test_oneshot();
        int seq[3] = '{2, 1, 0};
        oneshot = 4'b0100; load = 4'b0100; set_lv(2, 3);
        tick();
        load = '0;
        checks++; if (count[11:8] !== 4'd3) begin errors++; $display("FAIL oneshot_load got=%0d exp=3", count[11:8]); end
        enable = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (count[11:8] !== W'(seq[k]) || done[2] !== 1'b0)
                begin errors++; $display("FAIL oneshot_seq%0d got=%0d/%b exp=%0d/0", k, count[11:8], done[2], seq[k]); end
        end
        tick();
        checks++; if (done[2] !== 1'b1 || count[11:8] !== 4'd0) begin errors++; $display("FAIL oneshot_done got=%b/%0d exp=1/0", done[2], count[11:8]); end
        tick();
        checks++; if (done[2] !== 1'b1 || count[11:8] !== 4'd0) begin errors++; $display("FAIL oneshot_sticky got=%b/%0d exp=1/0", done[2], count[11:8]); end
        load = 4'b0100; set_lv(2, 4);
        tick();
        load = '0; enable = '0;
        checks++; if (done[2] !== 1'b0 || count[11:8] !== 4'd4) begin errors++; $display("FAIL oneshot_reload got=%b/%0d exp=0/4", done[2], count[11:8]); end
        oneshot = '0;
    endtask

    task automatic test_simultaneous();
        logic [CH*W-1:0] snap;
        logic [CH-1:0]   snapd;
        load = 4'b1000; set_lv(3, 1);
        tick();
        checks++; if (count[15:12] !== 4'd1) begin errors++; $display("FAIL simul_pre got=%0d exp=1", count[15:12]); end
        load = 4'b1000; enable = 4'b1000; set_lv(3, 7);
        tick();
        checks++; if (count[15:12] !== 4'd7) begin errors++; $display("FAIL simul_load_wins got=%0d exp=7", count[15:12]); end
        load = '0; enable = '0;
        snap = exp_count(); snapd = exp_done();
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (count !== snap || done !== snapd) begin errors++; $display("FAIL freeze_c%0d got=%h exp=%h", k, count, snap); end
        end
    endtask

    task automatic test_reset_mid();
        int rseq[3] = '{1, 0, 2};
        oneshot = 4'b0100; load = 4'b0101; set_lv(0, 1); set_lv(2, 0);
        tick();
        load = '0; enable = 4'b0100;
        tick();
        enable = '0;
        checks++; if (done[2] !== 1'b1 || count[3:0] !== 4'd1) begin errors++; $display("FAIL mid_setup got=%b/%0d exp=1/1", done[2], count[3:0]); end
        #2 resetN = 1'b0; model_reset();
        #1;
        checks++; if (count !== 16'h2222 || done !== 4'b0000) begin errors++; $display("FAIL mid_async got=%h/%b exp=2222/0000", count, done); end
        tick();
        resetN = 1'b1; oneshot = '0; enable = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (count[3:0] !== W'(rseq[k])) begin errors++; $display("FAIL mid_reload%0d got=%0d exp=%0d", k, count[3:0], rseq[k]); end
        end
        load = 4'b0001; set_lv(0, 0);
        tick();
        load = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (tc[0] !== 1'b1 || count[3:0] !== 4'd0) begin errors++; $display("FAIL zero_reload%0d got=%b/%0d exp=1/0", k, tc[0], count[3:0]); end
        end
        enable = '0;
    endtask

    task automatic test_cascade();
        int q[$];
        logic prev;
        int period = CASCADE ? 6 : 3;
        resetN = 1'b0; model_reset(); tick(); resetN = 1'b1;
        oneshot = '0; load = 4'b0011; set_lv(0, 1); set_lv(1, 2);
        tick();
        load = '0; enable = 4'b1111;
        prev = tc[1];
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (count !== exp_count()) begin errors++; $display("FAIL cascade_cnt_c%0d got=%h exp=%h", c, count, exp_count()); end
            if (tc[1] && !prev) q.push_back(c);
            prev = tc[1];
        end
        enable = '0;
        checks++; if (q.size() < 2) begin errors++; $display("FAIL cascade_rises got=%0d exp>=2", q.size()); end
        else if (q[1] - q[0] != period) begin errors++; $display("FAIL cascade_period got=%0d exp=%0d", q[1] - q[0], period); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                #1 resetN = 1'b0; model_reset();
                #1;
                checks++; if (count !== 16'h2222 || done !== 4'b0000) begin errors++; $display("FAIL rnd_reset_c%0d got=%h/%b exp=2222/0000", c, count, done); end
                tick();
                resetN = 1'b1;
            end
            enable = CH'($urandom);
            for (int i = 0; i < CH; i++) begin
                load[i] = ($urandom_range(0, 7) == 0);
                set_lv(i, $urandom_range(0, 5));
                if ($urandom_range(0, 15) == 0) oneshot[i] = ~oneshot[i];
            end
            tick();
            checks++; if (count !== exp_count() || tc !== exp_tc() || done !== exp_done())
                begin errors++; $display("FAIL rnd_c%0d got=%h/%b/%b exp=%h/%b/%b", c, count, tc, done, exp_count(), exp_tc(), exp_done()); end
        end
        enable = '0; load = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_autoreload();
        test_oneshot();
        test_simultaneous();
        test_reset_mid();
        test_cascade();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
